// File: rtl/adc_seq_pkg.sv
// Shared types and helpers for the LTC2308-class ADC scan sequencer.
`timescale 1ns/1ps
package adc_seq_pkg;

  typedef enum logic [2:0] {IDLE, CONV, SHIFT, DONE, WAIT} state_t;

  localparam int FRAME_BITS = 12;
  localparam int CFG_BITS   = 6;

  // Single-ended, unipolar, no sleep: {S/D, O/S, S1, S0, UNI, SLP}
  function automatic logic [CFG_BITS-1:0] cfg_word(input logic [2:0] ch);
    return {1'b1, ch[0], ch[2], ch[1], 1'b1, 1'b0};
  endfunction

endpackage

// File: rtl/adc_spi_shift.sv
// ADC SPI frame engine: 12 SCLK pulses, config word out on DIN, result in from DOUT.
// Handshake: a one-cycle start while idle launches a frame; done is high for the
// single cycle ending the last SCLK falling edge, when data holds the full word.
`timescale 1ns/1ps
module adc_spi_shift
  import adc_seq_pkg::*;
#(
  parameter int SCLK_HALF = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [CFG_BITS-1:0]   cfg,
  input  logic                  dout,
  output logic                  sclk,
  output logic                  din,
  output logic                  done,
  output logic [FRAME_BITS-1:0] data
);

  localparam logic [4:0]  LAST_EDGE = 5'(2 * FRAME_BITS - 1);
  localparam logic [15:0] HALF_LAST = 16'(SCLK_HALF - 1);

  logic                running;
  logic [15:0]         half_cnt;
  logic [4:0]          edge_cnt;
  logic [CFG_BITS-1:0] cfg_sr;
  logic                tick;

  assign tick = running && (half_cnt == HALF_LAST);
  assign done = tick && (edge_cnt == LAST_EDGE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      running  <= 1'b0;
      half_cnt <= '0;
      edge_cnt <= '0;
      sclk     <= 1'b0;
      din      <= 1'b0;
      cfg_sr   <= '0;
      data     <= '0;
    end else if (start && !running) begin
      // First config bit is presented a full half-period before the first rise.
      running  <= 1'b1;
      half_cnt <= '0;
      edge_cnt <= '0;
      sclk     <= 1'b0;
      din      <= cfg[CFG_BITS-1];
      cfg_sr   <= {cfg[CFG_BITS-2:0], 1'b0};
    end else if (running) begin
      if (tick) begin
        half_cnt <= '0;
        sclk     <= ~sclk;
        edge_cnt <= edge_cnt + 5'd1;
        if (!sclk) begin
          data <= {data[FRAME_BITS-2:0], dout};
        end else begin
          din    <= cfg_sr[CFG_BITS-1];
          cfg_sr <= {cfg_sr[CFG_BITS-2:0], 1'b0};
        end
        if (edge_cnt == LAST_EDGE) running <= 1'b0;
      end else begin
        half_cnt <= half_cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/adc_seq_ctrl.sv
// Round-robin ADC channel scanner with pipelined config/result frames.
// Optional ADC_SEQ_STATS_EN adds a saturating sample_count output.
`timescale 1ns/1ps
module adc_seq_ctrl
  import adc_seq_pkg::*;
#(
  parameter int SCLK_HALF     = 2,
  parameter int CONV_CYCLES   = 80,
  parameter int SAMPLE_PERIOD = 200
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [7:0]            ch_mask,
  output logic                  ADC_CS_N,
  output logic                  ADC_SCLK,
  output logic                  ADC_DIN,
  input  logic                  ADC_DOUT,
  output logic                  sample_valid,
  output logic [FRAME_BITS-1:0] sample_data,
  output logic [2:0]            sample_ch,
  output logic                  busy
`ifdef ADC_SEQ_STATS_EN
  ,
  output logic [15:0]           sample_count
`endif
);

  localparam int MIN_PERIOD = CONV_CYCLES + 24 * SCLK_HALF + 2;
  localparam int PERIOD     = (SAMPLE_PERIOD < MIN_PERIOD) ? MIN_PERIOD : SAMPLE_PERIOD;
  localparam logic [15:0] PERIOD_LAST = 16'(PERIOD - 1);
  localparam logic [15:0] CONV_LAST   = 16'(CONV_CYCLES - 1);

  // Next set mask bit above cur, wrapping; returns cur when it is the only one.
  function automatic logic [2:0] next_ch(input logic [7:0] mask, input logic [2:0] cur);
    logic [2:0] idx;
    next_ch = cur;
    for (int i = 7; i >= 1; i--) begin
      idx = cur + 3'(i);
      if (mask[idx]) next_ch = idx;
    end
  endfunction

  state_t                state;
  logic [15:0]           per_cnt;
  logic [2:0]            cur_ch;
  logic [2:0]            prev_ch;
  logic                  primed;
  logic                  start;
  logic                  spi_done;
  logic [FRAME_BITS-1:0] spi_data;

  // per_cnt restarts at each CONV entry, so CONV-to-CONV spacing equals CS_N rise spacing.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      ADC_CS_N     <= 1'b1;
      busy         <= 1'b0;
      start        <= 1'b0;
      per_cnt      <= '0;
      cur_ch       <= '0;
      prev_ch      <= '0;
      primed       <= 1'b0;
      sample_valid <= 1'b0;
      sample_data  <= '0;
      sample_ch    <= '0;
    end else begin
      start        <= 1'b0;
      sample_valid <= 1'b0;
      if (per_cnt != 16'hFFFF) per_cnt <= per_cnt + 16'd1;
      case (state)
        IDLE: begin
          if (enable && (ch_mask != 8'h00)) begin
            cur_ch  <= next_ch(ch_mask, 3'd7);
            primed  <= 1'b0;
            per_cnt <= '0;
            busy    <= 1'b1;
            state   <= CONV;
          end
        end
        CONV: begin
          if (per_cnt >= CONV_LAST) begin
            ADC_CS_N <= 1'b0;
            start    <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (spi_done) begin
            ADC_CS_N     <= 1'b1;
            sample_valid <= primed;
            if (primed) begin
              sample_data <= spi_data;
              sample_ch   <= prev_ch;
            end
            state <= DONE;
          end
        end
        DONE: begin
          primed  <= 1'b1;
          prev_ch <= cur_ch;
          if (!enable || (ch_mask == 8'h00)) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cur_ch <= next_ch(ch_mask, cur_ch);
            if (per_cnt >= PERIOD_LAST) begin
              per_cnt <= '0;
              state   <= CONV;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (per_cnt >= PERIOD_LAST) begin
            per_cnt <= '0;
            state   <= CONV;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  adc_spi_shift #(.SCLK_HALF(SCLK_HALF)) u_spi (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .cfg     (cfg_word(cur_ch)),
    .dout    (ADC_DOUT),
    .sclk    (ADC_SCLK),
    .din     (ADC_DIN),
    .done    (spi_done),
    .data    (spi_data)
  );

`ifdef ADC_SEQ_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sample_count <= '0;
    else if (sample_valid && (sample_count != 16'hFFFF)) sample_count <= sample_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_adc_seq_ctrl.sv
// Directed bench for adc_seq_ctrl with a behavioural serial ADC and a bus monitor.
`timescale 1ns/1ps
module tb_adc_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [7:0]  ch_mask = 8'h00;
  logic        adc_dout = 1'b0;
  logic        cs_n, sclk, din, valid, busy;
  logic [11:0] data;
  logic [2:0]  ch;
  logic        f_cs_n, f_sclk, f_din, f_valid, f_busy;
  logic [11:0] f_data;
  logic [2:0]  f_ch;
`ifdef ADC_SEQ_STATS_EN
  logic [15:0] count, f_count;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // clock / reset
  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adc_seq_ctrl dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .ch_mask(ch_mask),
    .ADC_CS_N(cs_n), .ADC_SCLK(sclk), .ADC_DIN(din), .ADC_DOUT(adc_dout),
    .sample_valid(valid), .sample_data(data), .sample_ch(ch), .busy(busy)
`ifdef ADC_SEQ_STATS_EN
    , .sample_count(count)
`endif
  );

  // Requested period below the minimum frame length: spacing must clamp to 130.
  adc_seq_ctrl #(.SAMPLE_PERIOD(10)) dut_fast (
    .clk(clk), .reset_n(reset_n), .enable(enable), .ch_mask(ch_mask),
    .ADC_CS_N(f_cs_n), .ADC_SCLK(f_sclk), .ADC_DIN(f_din), .ADC_DOUT(adc_dout),
    .sample_valid(f_valid), .sample_data(f_data), .sample_ch(f_ch), .busy(f_busy)
`ifdef ADC_SEQ_STATS_EN
    , .sample_count(f_count)
`endif
  );

  // ADC model: MSB after CS_N falls, next bit after each SCLK falling edge.
  logic [11:0] adc_word = 12'hA5C;
  int          adc_idx = 11;
  logic        cs_m = 1'b1, sclk_m = 1'b0;
  always @(negedge clk) begin
    if (cs_m && !cs_n) adc_idx = 11;
    else if (sclk_m && !sclk && adc_idx > 0) adc_idx = adc_idx - 1;
    adc_dout = adc_word[adc_idx];
    cs_m = cs_n;
    sclk_m = sclk;
  end

  // Monitor: sample stream, per-frame DIN word and SCLK rise count, CS_N rise times.
  int          v_cyc_q[$];
  logic [11:0] v_data_q[$];
  logic [2:0]  v_ch_q[$];
  logic [5:0]  din_q[$];
  int          rise_q[$];
  int          cs_rise_q[$];
  int          f_rise_q[$];
  int          rises = 0;
  logic [5:0]  din_w = '0;
  logic        cs_d = 1'b1, sclk_d = 1'b0, f_cs_d = 1'b1;
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      v_cyc_q.push_back(cyc);
      v_data_q.push_back(data);
      v_ch_q.push_back(ch);
    end
    if (!sclk_d && sclk) begin
      if (rises < 6) din_w = {din_w[4:0], din};
      rises++;
    end
    if (!cs_d && cs_n) begin
      din_q.push_back(din_w);
      rise_q.push_back(rises);
      cs_rise_q.push_back(cyc);
      rises = 0;
      din_w = '0;
    end
    if (!f_cs_d && f_cs_n) f_rise_q.push_back(cyc);
    cs_d = cs_n;
    sclk_d = sclk;
    f_cs_d = f_cs_n;
  end

  // driver / wait tasks
  task automatic wait_valids(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (v_cyc_q.size() >= target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_cs_low(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (cs_n === 1'b0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (busy === 1'b0 && f_busy === 1'b0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic stop_scan(input string name);
    bit ok;
    enable = 1'b0;
    wait_idle(600, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL %s_stop: busy=%b required 0 within 600 cycles", name, busy); end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b1; ch_mask = 8'h01;
    repeat (5) begin
      @(negedge clk);
      checks += 4;
      if (cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n: got %b required 1", cs_n); end
      if (sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b required 0", sclk); end
      if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", valid); end
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    end
    enable = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    checks += 4;
    if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b required 0", busy); end
    if (data !== 12'h000) begin errors++; $display("FAIL reset_data: got %h required 000", data); end
    if (ch !== 3'd0) begin errors++; $display("FAIL reset_ch: got %0d required 0", ch); end
    if (din !== 1'b0) begin errors++; $display("FAIL reset_din: got %b required 0", din); end
  endtask

  task automatic test_single_channel();
    bit ok;
    int base, cbase, fbase, e_cyc;
    adc_word = 12'hA5C; ch_mask = 8'h01;
    base = v_cyc_q.size(); cbase = cs_rise_q.size(); fbase = f_rise_q.size();
    @(negedge clk);
    e_cyc = cyc;
    enable = 1'b1;
    wait_valids(base + 3, 1000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_timeout: got %0d samples required 3", v_cyc_q.size() - base); return; end
    checks++;
    if (v_cyc_q[base] - e_cyc !== 330)
      begin errors++; $display("FAIL single_first_latency: got %0d required 330", v_cyc_q[base] - e_cyc); end
    for (int k = 0; k < 3; k++) begin
      checks += 2;
      if (v_data_q[base+k] !== 12'hA5C) begin errors++; $display("FAIL single_data[%0d]: got %h required a5c", k, v_data_q[base+k]); end
      if (v_ch_q[base+k] !== 3'd0) begin errors++; $display("FAIL single_ch[%0d]: got %0d required 0", k, v_ch_q[base+k]); end
    end
    for (int k = 1; k < 3; k++) begin
      checks++;
      if (v_cyc_q[base+k] - v_cyc_q[base+k-1] !== 200)
        begin errors++; $display("FAIL single_period[%0d]: got %0d required 200", k, v_cyc_q[base+k] - v_cyc_q[base+k-1]); end
    end
    checks += 3;
    if (cs_rise_q[cbase+1] - cs_rise_q[cbase] !== 200)
      begin errors++; $display("FAIL cs_rise_period: got %0d required 200", cs_rise_q[cbase+1] - cs_rise_q[cbase]); end
    if (rise_q[cbase] !== 12) begin errors++; $display("FAIL single_sclk_pulses: got %0d required 12", rise_q[cbase]); end
    if (f_rise_q[fbase+1] - f_rise_q[fbase] !== 130)
      begin errors++; $display("FAIL clamped_period: got %0d required 130", f_rise_q[fbase+1] - f_rise_q[fbase]); end
    stop_scan("single");
`ifdef ADC_SEQ_STATS_EN
    checks++;
    if (count !== 16'(v_cyc_q.size())) begin errors++; $display("FAIL sample_count: got %0d required %0d", count, v_cyc_q.size()); end
`endif
  endtask

  task automatic test_alternate();
    bit ok;
    int base, dbase;
    logic [5:0] exp_w;
    adc_word = 12'h3C1; ch_mask = 8'h05;
    base = v_cyc_q.size(); dbase = din_q.size();
    enable = 1'b1;
    wait_valids(base + 4, 1500, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL alt_timeout: got %0d samples required 4", v_cyc_q.size() - base); return; end
    for (int k = 0; k < 5; k++) begin
      exp_w = (k % 2 == 0) ? 6'b100010 : 6'b100110;
      checks += 2;
      if (din_q[dbase+k] !== exp_w) begin errors++; $display("FAIL alt_din_word[%0d]: got %b required %b", k, din_q[dbase+k], exp_w); end
      if (rise_q[dbase+k] !== 12) begin errors++; $display("FAIL alt_sclk_pulses[%0d]: got %0d required 12", k, rise_q[dbase+k]); end
    end
    for (int k = 0; k < 4; k++) begin
      checks += 2;
      if (v_ch_q[base+k] !== ((k % 2 == 0) ? 3'd0 : 3'd2))
        begin errors++; $display("FAIL alt_ch[%0d]: got %0d required %0d", k, v_ch_q[base+k], (k % 2 == 0) ? 0 : 2); end
      if (v_data_q[base+k] !== 12'h3C1) begin errors++; $display("FAIL alt_data[%0d]: got %h required 3c1", k, v_data_q[base+k]); end
    end
    stop_scan("alt");
  endtask

  task automatic test_disable_mid_frame();
    bit ok;
    int vb, dbase, e_cyc;
    adc_word = 12'hA5C; ch_mask = 8'h01;
    vb = v_cyc_q.size();
    enable = 1'b1;
    wait_valids(vb + 1, 600, ok);
    if (ok) wait_cs_low(300, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL dis_setup_timeout: cs_n=%b", cs_n); enable = 1'b0; return; end
    repeat (10) @(negedge clk);
    vb = v_cyc_q.size(); dbase = din_q.size();
    enable = 1'b0;
    wait_idle(300, ok);
    checks += 4;
    if (!ok) begin errors++; $display("FAIL dis_idle: busy=%b required 0", busy); end
    if (cs_n !== 1'b1) begin errors++; $display("FAIL dis_cs_n: got %b required 1", cs_n); end
    if (v_cyc_q.size() - vb !== 1) begin errors++; $display("FAIL dis_samples: got %0d required 1", v_cyc_q.size() - vb); end
    if (rise_q[dbase] !== 12) begin errors++; $display("FAIL dis_sclk_pulses: got %0d required 12", rise_q[dbase]); end
    repeat (300) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || v_cyc_q.size() - vb !== 1)
      begin errors++; $display("FAIL dis_stays_idle: busy=%b samples=%0d required busy 0 samples 1", busy, v_cyc_q.size() - vb); end
    vb = v_cyc_q.size();
    e_cyc = cyc;
    enable = 1'b1;
    repeat (300) @(negedge clk);
    checks++;
    if (v_cyc_q.size() !== vb) begin errors++; $display("FAIL reenable_prime: got %0d samples required 0", v_cyc_q.size() - vb); end
    wait_valids(vb + 1, 200, ok);
    checks++;
    if (!ok || v_cyc_q[vb] - e_cyc !== 330)
      begin errors++; $display("FAIL reenable_latency: got %0d required 330", ok ? v_cyc_q[vb] - e_cyc : -1); end
    stop_scan("dis");
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    int vb, n;
    logic sp;
    adc_word = 12'hA5C; ch_mask = 8'h01;
    vb = v_cyc_q.size();
    enable = 1'b1;
    wait_valids(vb + 1, 600, ok);
    if (ok) wait_cs_low(300, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rst_setup_timeout: cs_n=%b", cs_n); enable = 1'b0; return; end
    n = 0; sp = sclk;
    for (int i = 0; i < 100 && n < 5; i++) begin
      @(negedge clk);
      if (!sp && sclk) n++;
      sp = sclk;
    end
    checks++;
    if (n !== 5) begin errors++; $display("FAIL rst_sclk_rises: got %0d required 5", n); end
    #3 reset_n = 1'b0;
    #1;
    checks += 7;
    if (cs_n !== 1'b1) begin errors++; $display("FAIL rst_async_cs_n: got %b required 1", cs_n); end
    if (sclk !== 1'b0) begin errors++; $display("FAIL rst_async_sclk: got %b required 0", sclk); end
    if (din !== 1'b0) begin errors++; $display("FAIL rst_async_din: got %b required 0", din); end
    if (valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid: got %b required 0", valid); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_async_busy: got %b required 0", busy); end
    if (data !== 12'h000) begin errors++; $display("FAIL rst_async_data: got %h required 000", data); end
    if (ch !== 3'd0) begin errors++; $display("FAIL rst_async_ch: got %0d required 0", ch); end
    vb = v_cyc_q.size();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (300) @(negedge clk);
    checks++;
    if (v_cyc_q.size() !== vb) begin errors++; $display("FAIL rst_no_sample: got %0d samples required 0", v_cyc_q.size() - vb); end
    stop_scan("rst");
  endtask

  task automatic test_mask_zero();
    int bad, cb;
    ch_mask = 8'h00; cb = cs_rise_q.size(); bad = 0;
    enable = 1'b1;
    repeat (1000) begin
      @(negedge clk);
      if (cs_n !== 1'b1 || busy !== 1'b0 || sclk !== 1'b0) bad++;
    end
    checks += 2;
    if (bad !== 0) begin errors++; $display("FAIL mask_zero_activity: got %0d active cycles required 0", bad); end
    if (cs_rise_q.size() !== cb) begin errors++; $display("FAIL mask_zero_cs_toggle: got %0d frames required 0", cs_rise_q.size() - cb); end
    enable = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_mask_drop();
    bit ok;
    int dbase;
    ch_mask = 8'h01;
    enable = 1'b1;
    wait_cs_low(300, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL drop_setup_timeout: cs_n=%b", cs_n); enable = 1'b0; return; end
    dbase = din_q.size();
    ch_mask = 8'h00;
    wait_idle(300, ok);
    checks += 2;
    if (!ok) begin errors++; $display("FAIL drop_idle: busy=%b required 0", busy); end
    if (rise_q[dbase] !== 12) begin errors++; $display("FAIL drop_frame_complete: got %0d pulses required 12", rise_q[dbase]); end
    repeat (300) @(negedge clk);
    checks++;
    if (din_q.size() !== dbase + 1) begin errors++; $display("FAIL drop_no_restart: got %0d frames required 1", din_q.size() - dbase); end
    enable = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_channel();
    test_alternate();
    test_disable_mid_frame();
    test_reset_mid_frame();
    test_mask_zero();
    test_mask_drop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded 2 ms");
    $fatal(1, "watchdog");
  end

endmodule
